alu_wide_seq: RTL

Sequencing stage wrapped around the 6-bit ripple ALU slice array. Accepts one wide operation per valid/ready transaction. Runs it as `N_PASS` consecutive 6-bit passes through the external combinational ALU, least-significant slice first, with the carry chained through a register between passes. Returns the assembled result plus status flags through a valid/ready output. It both feeds the ALU's operand/op/carry-in inputs and consumes its `Result`/`CarryOut6` outputs.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_op_decode.sv | 36 +++
 rtl/alu_wide_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the wide ALU sequencer and its opcode decoder.
package alu_pkg;

    localparam int SLICE_W = 6;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Translates the 3-bit request opcode into the slice ALU's 4-bit ALUOp and
// the class flags the sequencer needs for carry and overflow handling.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] op,
    output logic [3:0] alu_op,
    output logic       is_sub,
    output logic       is_arith,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op   = ALUOP_AND;
        is_sub   = 1'b0;
        is_arith = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_AND: alu_op = ALUOP_AND;
            OP_OR:  alu_op = ALUOP_OR;
            OP_ADD: begin
                alu_op   = ALUOP_ADD;
                is_arith = 1'b1;
            end
            OP_SUB: begin
                alu_op   = ALUOP_SUB;
                is_sub   = 1'b1;
                is_arith = 1'b1;
            end
            OP_NOR: alu_op = ALUOP_NOR;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_wide_seq.sv
// Runs one wide operation as N_PASS chained passes through an external 6-bit
// combinational ALU, least-significant slice first, and returns result + flags.
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int N_PASS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [SLICE_W*N_PASS-1:0]  in_a,
    input  logic [SLICE_W*N_PASS-1:0]  in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*N_PASS-1:0]  out_result,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_ovf,
    output logic                       out_err,
    output logic [SLICE_W-1:0]         alu_a,
    output logic [SLICE_W-1:0]         alu_b,
    output logic                       alu_cin,
    output logic [3:0]                 alu_op,
    input  logic [SLICE_W-1:0]         alu_result,
    input  logic                       alu_cout
);

    localparam int W  = SLICE_W * N_PASS;
    localparam int PW = (N_PASS > 1) ? $clog2(N_PASS) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_PASS - 1);

    state_t        state;
    logic [W-1:0]  a_q, b_q, result_q;
    logic [3:0]    alu_op_q;
    logic          sub_q, arith_q, carry_q;
    logic [PW-1:0] p;

    logic [3:0]    dec_alu_op;
    logic          dec_sub, dec_arith, dec_illegal;
    logic          accept;
    logic [W-1:0]  result_next;
    logic          ovf_next;

    alu_op_decode u_decode (
        .op       (in_op),
        .alu_op   (dec_alu_op),
        .is_sub   (dec_sub),
        .is_arith (dec_arith),
        .illegal  (dec_illegal)
    );

    assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready;

    // ALU is driven only while running; idle drive is all zeros.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = ALUOP_AND;
        alu_cin = 1'b0;
        if (state == ST_RUN) begin
            alu_a   = a_q[int'(p)*SLICE_W +: SLICE_W];
            alu_b   = b_q[int'(p)*SLICE_W +: SLICE_W];
            alu_op  = alu_op_q;
            alu_cin = (p == '0) ? sub_q : (arith_q & carry_q);
        end
    end

    // Result with the current pass's slice merged in, so flags see the final value.
    always_comb begin
        result_next = result_q;
        result_next[int'(p)*SLICE_W +: SLICE_W] = alu_result;
        ovf_next = 1'b0;
        if (arith_q) begin
            if (sub_q)
                ovf_next = (a_q[W-1] != b_q[W-1]) && (result_next[W-1] != a_q[W-1]);
            else
                ovf_next = (a_q[W-1] == b_q[W-1]) && (result_next[W-1] != a_q[W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: working registers are reset too; they are few flops, not a memory array.
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            alu_op_q   <= ALUOP_AND;
            sub_q      <= 1'b0;
            arith_q    <= 1'b0;
            carry_q    <= 1'b0;
            p          <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            a_q      <= in_a;
            b_q      <= in_b;
            alu_op_q <= dec_alu_op;
            sub_q    <= dec_sub;
            arith_q  <= dec_arith;
            carry_q  <= 1'b0;
            p        <= '0;
            if (dec_illegal) begin
                state      <= ST_DONE;
                out_valid  <= 1'b1;
                out_result <= '0;
                out_carry  <= 1'b0;
                out_zero   <= 1'b1;
                out_neg    <= 1'b0;
                out_ovf    <= 1'b0;
                out_err    <= 1'b1;
            end else begin
                state     <= ST_RUN;
                out_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    result_q <= result_next;
                    carry_q  <= alu_cout;
                    if (p == LAST) begin
                        state      <= ST_DONE;
                        p          <= '0;
                        out_valid  <= 1'b1;
                        out_result <= result_next;
                        out_carry  <= arith_q & alu_cout;
                        out_zero   <= (result_next == '0);
                        out_neg    <= result_next[W-1];
                        out_ovf    <= ovf_next;
                        out_err    <= 1'b0;
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
